// File: rtl/qif_pkg.sv
// Shared types and widths for the QIF spike decoder.
package qif_pkg;

  localparam int unsigned ValW = 8;
  localparam int unsigned WinW = 24;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  function automatic logic [ValW-1:0] sat_inc(input logic [ValW-1:0] v);
    return (v == {ValW{1'b1}}) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/qif_window_timer.sv
// Rate-measurement window counter: 0..WINDOW-1, tc pulses on the last cycle.
module qif_window_timer
  import qif_pkg::*;
#(
  parameter logic [WinW-1:0] WINDOW = 24'd10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [WinW-1:0] r_wcnt;
  logic            w_last;

  assign w_last = (r_wcnt == WINDOW - 24'd1);
  assign tc     = en && !clr && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt <= '0;
    end else if (clr) begin
      r_wcnt <= '0;
    end else if (en) begin
      r_wcnt <= w_last ? '0 : r_wcnt + 24'd1;
    end
  end

endmodule

// File: rtl/qif_spike_decoder.sv
// Detects rising threshold crossings of a QIF membrane value and reports the
// per-window spike count through a valid/ready register with sticky overrun.
module qif_spike_decoder
  import qif_pkg::*;
#(
  parameter logic [WinW-1:0] WINDOW = 24'd10_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [ValW-1:0] v_mem,
  input  logic [ValW-1:0] thresh,
  output logic            spike,
  output logic [ValW-1:0] rate,
  output logic            rate_valid,
  input  logic            rate_ready,
  output logic            overrun
);

  state_e          r_state;
  state_e          w_state_d;
  logic            r_above;
  logic            r_spike;
  logic [ValW-1:0] r_scnt;
  logic [ValW-1:0] r_rate;
  logic            r_rate_valid;
  logic            r_overrun;

  logic            w_ge;
  logic            w_count;
  logic            w_det;
  logic            w_tc;
  logic [ValW-1:0] w_final;

  assign w_ge    = (v_mem >= thresh);
  assign w_count = (r_state == COUNT);
  assign w_det   = w_count && w_ge && !r_above;
  assign w_final = w_det ? sat_inc(r_scnt) : r_scnt;

  qif_window_timer #(
    .WINDOW(WINDOW)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (!w_count),
    .en   (w_count),
    .tc   (w_tc)
  );

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE:    if (ena) w_state_d = COUNT;
      COUNT:   if (!ena) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_above      <= 1'b0;
      r_spike      <= 1'b0;
      r_scnt       <= '0;
      r_rate       <= '0;
      r_rate_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      // above tracks in IDLE too, so a level already high at enable is not a spike
      r_above <= w_ge;
      r_spike <= w_det;

      if (!w_count) begin
        r_scnt <= '0;
      end else if (w_tc) begin
        r_scnt <= w_det ? 8'd1 : 8'd0;
      end else begin
        r_scnt <= w_final;
      end

      // A window end wins over a simultaneous accept: the new result is loaded
      if (w_tc) begin
        r_rate       <= w_final;
        r_rate_valid <= 1'b1;
        if (r_rate_valid && !rate_ready) r_overrun <= 1'b1;
      end else if (r_rate_valid && rate_ready) begin
        r_rate_valid <= 1'b0;
        r_overrun    <= 1'b0;
      end
    end
  end

  assign spike      = r_spike;
  assign rate       = r_rate;
  assign rate_valid = r_rate_valid;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_qif_spike_decoder.sv
// Directed bench: WINDOW=16 instance for most scenarios, WINDOW=1024 for saturation.
module tb_qif_spike_decoder;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] v_mem;
  logic [7:0] thresh;
  logic       spike;
  logic [7:0] rate;
  logic       rate_valid;
  logic       rate_ready;
  logic       overrun;

  logic       ena2;
  logic [7:0] v2;
  logic       spike2;
  logic [7:0] rate2;
  logic       rate_valid2;
  logic       rate_ready2;
  logic       overrun2;

  int checks   = 0;
  int failures = 0;

  qif_spike_decoder #(
    .WINDOW(24'd16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .v_mem     (v_mem),
    .thresh    (thresh),
    .spike     (spike),
    .rate      (rate),
    .rate_valid(rate_valid),
    .rate_ready(rate_ready),
    .overrun   (overrun)
  );

  qif_spike_decoder #(
    .WINDOW(24'd1024)
  ) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena2),
    .v_mem     (v2),
    .thresh    (thresh),
    .spike     (spike2),
    .rate      (rate2),
    .rate_valid(rate_valid2),
    .rate_ready(rate_ready2),
    .overrun   (overrun2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    rst_n       = 1'b0;
    ena         = 1'b0;
    ena2        = 1'b0;
    v_mem       = 8'd0;
    v2          = 8'd0;
    rate_ready  = 1'b0;
    rate_ready2 = 1'b0;
    thresh      = 8'd100;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0; ena2 = 1'b0; v_mem = 8'd0; v2 = 8'd0;
    thresh = 8'd100; rate_ready = 1'b0; rate_ready2 = 1'b0;
    tick();
    checks++;
    if (spike !== 1'b0) begin failures++; $display("FAIL reset_spike got=%0d exp=0", spike); end
    checks++;
    if (rate !== 8'd0) begin failures++; $display("FAIL reset_rate got=%0d exp=0", rate); end
    checks++;
    if (rate_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%0d exp=0", rate_valid);
    end
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0d exp=0", overrun); end
  endtask

  task automatic test_single();
    int nsp;
    int v;
    restart();
    ena = 1'b1;
    nsp = 0;
    for (int j = 1; j <= 17; j++) begin
      v = (j * 20 > 120) ? 120 : j * 20;
      v_mem = 8'(v);
      tick();
      if (spike === 1'b1) nsp++;
      if (j == 16) begin
        checks++;
        if (rate_valid !== 1'b0) begin
          failures++; $display("FAIL single_early_valid got=%0d exp=0", rate_valid);
        end
      end
    end
    checks++;
    if (nsp != 1) begin failures++; $display("FAIL single_spikes got=%0d exp=1", nsp); end
    checks++;
    if (rate_valid !== 1'b1 || rate !== 8'd1) begin
      failures++; $display("FAIL single_rate got=%0d/%0d exp=1/1", rate, rate_valid);
    end
    rate_ready = 1'b1;
    tick();
    rate_ready = 1'b0;
    checks++;
    if (rate_valid !== 1'b0 || rate !== 8'd1) begin
      failures++; $display("FAIL single_accept got=%0d/%0d exp=1/0", rate, rate_valid);
    end
  endtask

  task automatic test_toggle();
    restart();
    rate_ready = 1'b1;
    ena = 1'b1;
    for (int j = 1; j <= 49; j++) begin
      v_mem = (((j - 1) / 2) % 2 == 1) ? 8'd200 : 8'd0;
      tick();
      if (j == 17 || j == 33 || j == 49) begin
        checks++;
        if (rate !== 8'd4 || rate_valid !== 1'b1 || overrun !== 1'b0) begin
          failures++;
          $display("FAIL toggle_rate j=%0d got=%0d/%0d/%0d exp=4/1/0", j, rate, rate_valid, overrun);
        end
      end
      if (j == 18) begin
        checks++;
        if (rate_valid !== 1'b0) begin
          failures++; $display("FAIL toggle_accept got=%0d exp=0", rate_valid);
        end
      end
    end
  endtask

  task automatic test_overrun();
    restart();
    ena = 1'b1;
    for (int j = 1; j <= 33; j++) begin
      v_mem = (j == 5 || j == 20 || j == 25) ? 8'd200 : 8'd0;
      tick();
      if (j == 17) begin
        checks++;
        if (rate !== 8'd1 || rate_valid !== 1'b1 || overrun !== 1'b0) begin
          failures++;
          $display("FAIL ovr_first got=%0d/%0d/%0d exp=1/1/0", rate, rate_valid, overrun);
        end
      end
    end
    checks++;
    if (rate !== 8'd2 || rate_valid !== 1'b1 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_second got=%0d/%0d/%0d exp=2/1/1", rate, rate_valid, overrun);
    end
    rate_ready = 1'b1;
    tick();
    rate_ready = 1'b0;
    checks++;
    if (rate_valid !== 1'b0 || overrun !== 1'b0 || rate !== 8'd2) begin
      failures++;
      $display("FAIL ovr_accept got=%0d/%0d/%0d exp=2/0/0", rate, rate_valid, overrun);
    end
  endtask

  task automatic test_boundary();
    restart();
    rate_ready = 1'b1;
    ena = 1'b1;
    for (int j = 1; j <= 33; j++) begin
      v_mem = (j == 10 || j == 17 || j == 25) ? 8'd200 : 8'd0;
      tick();
      if (j == 17) begin
        checks++;
        if (spike !== 1'b1) begin failures++; $display("FAIL bound_spike got=%0d exp=1", spike); end
        checks++;
        if (rate !== 8'd2 || rate_valid !== 1'b1) begin
          failures++; $display("FAIL bound_close got=%0d/%0d exp=2/1", rate, rate_valid);
        end
      end
    end
    // one carried spike plus one new spike
    checks++;
    if (rate !== 8'd2 || rate_valid !== 1'b1) begin
      failures++; $display("FAIL bound_carry got=%0d/%0d exp=2/1", rate, rate_valid);
    end
  endtask

  task automatic test_idle_above();
    int nsp;
    restart();
    v_mem = 8'd200;
    tick();
    tick();
    checks++;
    if (spike !== 1'b0) begin failures++; $display("FAIL idle_spike got=%0d exp=0", spike); end
    ena = 1'b1;
    nsp = 0;
    for (int j = 1; j <= 17; j++) begin
      tick();
      if (spike === 1'b1) nsp++;
    end
    checks++;
    if (nsp != 0) begin failures++; $display("FAIL idle_held_spikes got=%0d exp=0", nsp); end
    checks++;
    if (rate !== 8'd0 || rate_valid !== 1'b1) begin
      failures++; $display("FAIL idle_rate got=%0d/%0d exp=0/1", rate, rate_valid);
    end
  endtask

  task automatic test_saturate();
    restart();
    ena2 = 1'b1;
    for (int j = 1; j <= 1025; j++) begin
      v2 = ((j % 2 == 1) && j <= 601) ? 8'd200 : 8'd0;
      tick();
      if (j == 1024) begin
        checks++;
        if (rate_valid2 !== 1'b0) begin
          failures++; $display("FAIL sat_early got=%0d exp=0", rate_valid2);
        end
      end
    end
    checks++;
    if (rate2 !== 8'd255 || rate_valid2 !== 1'b1 || overrun2 !== 1'b0) begin
      failures++;
      $display("FAIL sat_rate got=%0d/%0d/%0d exp=255/1/0", rate2, rate_valid2, overrun2);
    end
    ena2 = 1'b0;
  endtask

  task automatic test_abort();
    restart();
    ena = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      v_mem = (j == 4) ? 8'd200 : 8'd0;
      tick();
    end
    ena = 1'b0;
    v_mem = 8'd0;
    for (int j = 0; j < 21; j++) tick();
    checks++;
    if (rate_valid !== 1'b0 || rate !== 8'd0) begin
      failures++; $display("FAIL abort_partial got=%0d/%0d exp=0/0", rate, rate_valid);
    end
    ena = 1'b1;
    for (int j = 1; j <= 25; j++) begin
      v_mem = (j == 6) ? 8'd200 : 8'd0;
      tick();
      if (j == 17) begin
        checks++;
        if (rate !== 8'd1 || rate_valid !== 1'b1) begin
          failures++; $display("FAIL abort_reenable got=%0d/%0d exp=1/1", rate, rate_valid);
        end
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (spike !== 1'b0 || rate !== 8'd0 || rate_valid !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset got=%0d/%0d/%0d/%0d exp=0/0/0/0", spike, rate, rate_valid,
               overrun);
    end
    tick();
    rst_n = 1'b1;
    for (int j = 1; j <= 17; j++) begin
      v_mem = (j == 5) ? 8'd200 : 8'd0;
      tick();
      if (j == 16) begin
        checks++;
        if (rate_valid !== 1'b0) begin
          failures++; $display("FAIL abort_early got=%0d exp=0", rate_valid);
        end
      end
    end
    checks++;
    if (rate !== 8'd1 || rate_valid !== 1'b1) begin
      failures++; $display("FAIL abort_after got=%0d/%0d exp=1/1", rate, rate_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_toggle();
    test_overrun();
    test_boundary();
    test_idle_above();
    test_saturate();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qif_spike_decoder.md
QIF_SPIKE_DECODER -- requirements
Module: qif_spike_decoder

Interface
REQ-001 SHALL have parameter WINDOW, default 24'd10_000_000, meaning the rate-measurement window length in clk cycles (legal range 2..2^24-1).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-004 SHALL have port ena, input, 1, meaning decoder enable; low forces IDLE.
REQ-005 SHALL have port v_mem, input, 8, meaning the unsigned membrane value from the QIF neuron output.
REQ-006 SHALL have port thresh, input, 8, meaning the unsigned spike-detect threshold.
REQ-007 SHALL have port spike, output, 1, meaning a one-cycle pulse per detected spike.
REQ-008 SHALL have port rate, output, 8, meaning the spike count of the last completed window.
REQ-009 SHALL have port rate_valid, output, 1, meaning rate holds an unconsumed result.
REQ-010 SHALL have port rate_ready, input, 1, meaning the consumer accepts rate.
REQ-011 SHALL have port overrun, output, 1, meaning a result was overwritten before acceptance (sticky).

Function
REQ-012 SHALL implement FSM states IDLE and COUNT; IDLE->COUNT when ena=1; any state->IDLE when ena=0.
REQ-013 SHALL keep register above <= (v_mem >= thresh) every cycle in all states, unsigned compare, equality counts as above.
REQ-014 SHALL register spike <= (state==COUNT) && (v_mem >= thresh) && !above: one-cycle latency; rising crossings only; a level held above thresh yields one spike.
REQ-015 SHALL not report a spike on the first COUNT cycle if v_mem was already above thresh in IDLE, because above keeps updating in IDLE.
REQ-016 SHALL run window counter wcnt 0..WINDOW-1 in COUNT, wrapping to 0; wcnt and spike count scnt cleared on entry to COUNT.
REQ-017 SHALL increment scnt on each detected spike, saturating at 255.
REQ-018 SHALL on the edge where wcnt==WINDOW-1 load rate with the final count, including a spike detected at that same edge, set rate_valid, and reset scnt to 0, or to 1 if a spike is detected at that edge.
REQ-019 SHALL clear rate_valid on the edge where rate_valid && rate_ready, with no other change to rate.
REQ-020 SHALL, when window end and rate_valid=1 without rate_ready coincide, overwrite rate, keep rate_valid=1, and set overrun.
REQ-021 SHALL, when window end and acceptance coincide, treat it as load (rate_valid stays 1, overrun unchanged).
REQ-022 SHALL clear overrun only on an accepted transfer that does not coincide with an overwrite.
REQ-023 SHALL in IDLE hold rate, rate_valid and overrun, keep spike=0, and allow the handshake to complete.
REQ-024 SHALL discard a partial window when ena falls mid-window; no result is produced.
REQ-025 SHALL produce the first result exactly WINDOW cycles after the first COUNT cycle.

Reset
REQ-026 SHALL on rst_n=0 asynchronously force: state=IDLE, wcnt=0, scnt=0, above=0, spike=0, rate=0, rate_valid=0, overrun=0.
REQ-027 SHALL release reset synchronously to clk; the first COUNT cycle is no earlier than the first edge after release with ena=1.
REQ-028 SHALL abort any in-progress window when reset is asserted mid-window; no partial result survives.

Structure
REQ-029 SHALL place the state enum (IDLE, COUNT), the 8-bit value width and the 24-bit window width in shared package qif_pkg.
REQ-030 SHALL isolate the window counter in sub-module qif_window_timer (clk, rst_n, clr, en -> tc pulse at WINDOW-1).
REQ-031 SHALL hold all outputs in registers; no combinational path from input to output except none.

Verification (WINDOW=16)
REQ-032 SHALL cover: thresh=100, v_mem ramps 0->120 once, held -> exactly one spike pulse; rate=1 at window end.
REQ-033 SHALL cover: v_mem toggles 0/200 every 2 cycles, rate_ready=1 -> rate=4 each window, overrun=0.
REQ-034 SHALL cover: 300 crossings in one window, with WINDOW=1024 as a parameter override -> rate=255 (saturated).
REQ-035 SHALL cover: rate_ready=0 across two window ends -> rate = second count, rate_valid=1, overrun=1; then rate_ready=1 for one cycle -> rate_valid=0, overrun=0.
REQ-036 SHALL cover: crossing at wcnt==15 -> counted in closing window; next window starts with scnt=1.
REQ-037 SHALL cover: ena dropped at wcnt=8, then rst_n pulsed low mid-window -> no result, all outputs 0 after reset, next result exactly 16 cycles after re-enable.
